// File: rtl/afifo_pkg.sv
// Shared types for the AFIFO read-side drain: FSM state encoding and a saturating counter helper.
package afifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } drain_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/afifo_drain_buf.sv
// 2-entry order-preserving valid/ready buffer; data appears at the output the cycle after push.
// Push is unconditional: the producer must only push while cnt_o < 2 (or with a same-cycle pop).
module stream_buf2 #(
    parameter int Width = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [Width-1:0] in_dat_i,
    output logic             out_vld_o,
    output logic [Width-1:0] out_dat_o,
    input  logic             out_rdy_i,
    output logic [1:0]       cnt_o
);
    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop;

    assign pop = out_rdy_i && (cnt_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({in_vld_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = in_dat_i;
                else               tail_d = in_dat_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    head_d = in_dat_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = head_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/afifo_drain.sv
// AFIFO read-side drain: pops the FIFO into a 2-entry stream buffer, counts words, checks sequence.
// Pop-to-capture latency 0, out_valid one cycle later; reads stop while the buffer is full.
module afifo_drain
    import afifo_pkg::*;
#(
    parameter int Width       = 12,
    parameter int CountWidth  = 16,
    parameter bit HaltOnError = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  r,
    input  logic [Width-1:0]      rd,
    input  logic                  rempty,
    output logic                  out_valid,
    output logic [Width-1:0]      out_data,
    input  logic                  out_ready,
    input  logic                  check_en,
    input  logic                  err_clr,
    output logic                  err,
    output logic [CountWidth-1:0] err_count,
    output logic [CountWidth-1:0] word_count
);
    drain_state_t          state_q, state_d;
    logic [Width-1:0]      expect_q, expect_d;
    logic                  err_q, err_d;
    logic [CountWidth-1:0] err_count_q, err_count_d;
    logic [CountWidth-1:0] word_count_q, word_count_d;
    logic [1:0]            cnt;
    logic                  mismatch;

    // Gated on registered occupancy only, so out_ready never reaches r combinationally.
    assign r        = (state_q == RUN) && en && !rempty && (cnt < 2'd2);
    assign mismatch = r && check_en && (rd != expect_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
                if (mismatch && HaltOnError) state_d = HALT;
                else if (!en)                state_d = IDLE;
            end
            HALT: if (err_clr) state_d = en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        expect_d     = expect_q;
        err_d        = err_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        // Every pop leaves expect at rd+1: match, resync after mismatch and unchecked tracking agree.
        if (r) begin
            expect_d     = rd + Width'(1);
            word_count_d = CountWidth'(sat_inc(32'(word_count_q), CountWidth));
        end
        if (mismatch) begin
            err_d       = 1'b1;
            err_count_d = CountWidth'(sat_inc(32'(err_count_q), CountWidth));
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            expect_q     <= '0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            expect_q     <= expect_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    stream_buf2 #(
        .Width(Width)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (r),
        .in_dat_i  (rd),
        .out_vld_o (out_valid),
        .out_dat_o (out_data),
        .out_rdy_i (out_ready),
        .cnt_o     (cnt)
    );

    assign err        = err_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_afifo_drain.sv
// Directed bench for afifo_drain: FIFO models feed two instances (halt / no-halt), scoreboards check the stream.
module tb_afifo_drain;
    logic        clk = 1'b0;
    logic        rst, out_ready, check_en, err_clr;
    logic        en_a, r_a, rempty_a, ov_a, err_a;
    logic [11:0] rd_a, od_a;
    logic [15:0] ec_a, wc_a;
    logic        en_b, r_b, rempty_b, ov_b, err_b;
    logic [11:0] rd_b, od_b;
    logic [15:0] ec_b, wc_b;

    logic [11:0] fifo_a[$], fifo_b[$], exp_a[$], exp_b[$];
    logic        fire_a, fire_b, xfer_a, xfer_b;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          pushed;
    logic [11:0] nextv;

    always #3 clk = ~clk;

    afifo_drain #(.Width(12), .CountWidth(16), .HaltOnError(1'b1)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .r(r_a), .rd(rd_a), .rempty(rempty_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
        .check_en(check_en), .err_clr(err_clr), .err(err_a),
        .err_count(ec_a), .word_count(wc_a)
    );

    afifo_drain #(.Width(12), .CountWidth(16), .HaltOnError(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .r(r_b), .rd(rd_b), .rempty(rempty_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready),
        .check_en(check_en), .err_clr(err_clr), .err(err_b),
        .err_count(ec_b), .word_count(wc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        rempty_a = (fifo_a.size() == 0);
        rd_a     = rempty_a ? 12'h000 : fifo_a[0];
        rempty_b = (fifo_b.size() == 0);
        rd_b     = rempty_b ? 12'h000 : fifo_b[0];
    endtask

    task automatic push_a(input logic [11:0] v);
        fifo_a.push_back(v);
        exp_a.push_back(v);
        refresh();
    endtask

    task automatic push_b(input logic [11:0] v);
        fifo_b.push_back(v);
        exp_b.push_back(v);
        refresh();
    endtask

    task automatic check_xfer(input string tag, input logic [11:0] data, inout logic [11:0] q[$]);
        if (q.size() == 0) begin
            tests_run++;
            assert (q.size() != 0) else begin
                tests_failed++;
                $error("FAIL %s_extra: observed word %0h, expected no word", tag, data);
            end
        end else begin
            chk(tag, 32'(data), 32'(q.pop_front()));
        end
    endtask

    // One clock: sample at negedge, then let the FIFO model follow the edge.
    task automatic step();
        @(negedge clk);
        fire_a = r_a & !rempty_a;
        fire_b = r_b & !rempty_b;
        xfer_a = ov_a & out_ready;
        xfer_b = ov_b & out_ready;
        if (xfer_a === 1'b1) check_xfer("a_data", od_a, exp_a);
        if (xfer_b === 1'b1) check_xfer("b_data", od_b, exp_b);
        @(posedge clk);
        #1;
        if (fire_a === 1'b1) void'(fifo_a.pop_front());
        if (fire_b === 1'b1) void'(fifo_b.pop_front());
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; out_ready = 1'b0;
        check_en = 1'b0; err_clr = 1'b0;
        refresh();
        steps(3);
        chk("rst_r", 32'(r_a), 32'd0);
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_out_data", 32'(od_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_err_count", 32'(ec_a), 32'd0);
        chk("rst_word_count", 32'(wc_a), 32'd0);
        rst = 1'b0;

        // 0..9 streamed at one word per clock
        for (int i = 0; i < 10; i++) push_a(12'(i));
        en_a = 1'b1; check_en = 1'b1; out_ready = 1'b1;
        steps(12);
        chk("burst_left", 32'(exp_a.size()), 32'd0);
        chk("burst_word_count", 32'(wc_a), 32'd10);
        chk("burst_err", 32'(err_a), 32'd0);

        // Backpressure: only two pops, head held
        out_ready = 1'b0;
        for (int i = 10; i < 15; i++) push_a(12'(i));
        steps(4);
        chk("bp_word_count", 32'(wc_a), 32'd12);
        chk("bp_r", 32'(r_a), 32'd0);
        chk("bp_out_valid", 32'(ov_a), 32'd1);
        chk("bp_out_data", 32'(od_a), 32'd10);
        out_ready = 1'b1;
        steps(8);
        chk("bp_left", 32'(exp_a.size()), 32'd0);
        chk("bp_word_count_end", 32'(wc_a), 32'd15);

        // Silent resync to 2, then 3,4,7,8 with halt on 7
        check_en = 1'b0;
        push_a(12'd2);
        steps(3);
        chk("resync_err", 32'(err_a), 32'd0);
        check_en = 1'b1;
        push_a(12'd3); push_a(12'd4); push_a(12'd7); push_a(12'd8);
        steps(6);
        chk("halt_err", 32'(err_a), 32'd1);
        chk("halt_err_count", 32'(ec_a), 32'd1);
        chk("halt_word_count", 32'(wc_a), 32'd19);
        chk("halt_r", 32'(r_a), 32'd0);
        chk("halt_left", 32'(exp_a.size()), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", 32'(err_a), 32'd0);
        steps(4);
        chk("resume_err", 32'(err_a), 32'd0);
        chk("resume_err_count", 32'(ec_a), 32'd1);
        chk("resume_word_count", 32'(wc_a), 32'd20);
        chk("resume_left", 32'(exp_a.size()), 32'd0);

        // Dropping en stops reads in the same cycle
        push_a(12'd9); push_a(12'd10); push_a(12'd11);
        step();
        en_a = 1'b0;
        #1;
        chk("en_drop_r", 32'(r_a), 32'd0);
        steps(3);
        chk("en_drop_word_count", 32'(wc_a), 32'd21);
        chk("en_drop_out_valid", 32'(ov_a), 32'd0);
        chk("en_drop_left", 32'(exp_a.size()), 32'd2);

        // Reset with a full buffer
        out_ready = 1'b0; en_a = 1'b1;
        steps(4);
        chk("full_out_valid", 32'(ov_a), 32'd1);
        chk("full_out_data", 32'(od_a), 32'd10);
        exp_a.delete();
        rst = 1'b1; en_a = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(ov_a), 32'd0);
        chk("mid_rst_word_count", 32'(wc_a), 32'd0);
        chk("mid_rst_err_count", 32'(ec_a), 32'd0);
        push_a(12'd0);
        en_a = 1'b1;
        #1;
        chk("mid_rst_idle_r", 32'(r_a), 32'd0);
        step();
        chk("mid_rst_run_r", 32'(r_a), 32'd1);
        out_ready = 1'b1;
        steps(3);
        chk("post_rst_err", 32'(err_a), 32'd0);
        chk("post_rst_word_count", 32'(wc_a), 32'd1);
        chk("post_rst_left", 32'(exp_a.size()), 32'd0);
        en_a = 1'b0;

        // No-halt instance across the 12-bit wrap
        check_en = 1'b0;
        push_b(12'hFFD);
        en_b = 1'b1;
        steps(4);
        check_en = 1'b1;
        push_b(12'hFFE); push_b(12'hFFF); push_b(12'h000); push_b(12'h005); push_b(12'h006);
        steps(3);
        chk("wrap_err", 32'(err_b), 32'd0);
        steps(5);
        chk("nohalt_err", 32'(err_b), 32'd1);
        chk("nohalt_err_count", 32'(ec_b), 32'd1);
        chk("nohalt_word_count", 32'(wc_b), 32'd6);
        chk("nohalt_left", 32'(exp_b.size()), 32'd0);
        en_b = 1'b0;

        // Slow counter writer with random stalls on both sides
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_a = 1'b1;
        nextv = 12'd0;
        pushed = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_a.size() < 6) begin
                push_a(nextv);
                nextv = nextv + 12'd1;
                pushed++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (fifo_a.size() != 0 || exp_a.size() != 0); i++) step();
        chk("sys_drained", 32'(exp_a.size() + fifo_a.size()), 32'd0);
        chk("sys_err", 32'(err_a), 32'd0);
        chk("sys_word_count", 32'(wc_a), 32'(pushed));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
